// File: rtl/mem_responder_if.sv
// mem_responder_if: processor memory port bundle between requester and mem_responder.
//   addr     word address of the request
//   data_in  write data from the processor
//   rd, wr   level request strobes
//   data_out read data, valid with ready on a read
//   ready    one-cycle completion pulse
//   error    one-cycle error flag (illegal request or out-of-range access)
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 26
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data_in;
    logic                  rd;
    logic                  wr;
    logic [31:0]           data_out;
    logic                  ready;
    logic                  error;

    modport master (output addr, data_in, rd, wr, input data_out, ready, error);
    modport slave  (input addr, data_in, rd, wr, output data_out, ready, error);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory responder with programmable wait states and one-cycle READY.
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset (backing store is not cleared)
//   bus     mem_responder_if slave port: addr/data_in/rd/wr in, data_out/ready/error out
module mem_responder #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  wr_q, wr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [31:0]           mem_q [2**DEPTH_LOG2];
    logic                  accept, illegal, access, in_range;
    logic [DEPTH_LOG2-1:0] idx;

    assign accept   = state_q == IDLE && (bus.rd ^ bus.wr);
    assign illegal  = state_q == IDLE && bus.rd && bus.wr;
    assign access   = state_q == BUSY && cnt_q == 4'd0;
    // any address bit at or above DEPTH_LOG2 puts the access out of range
    assign in_range = (addr_q >> DEPTH_LOG2) == '0;
    assign idx      = addr_q[DEPTH_LOG2-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (access && wr_q && in_range) mem_q[idx] <= data_q;
    end

    always_comb begin
        state_d = accept ? BUSY : access ? DONE : state_q == DONE ? IDLE : state_q;
    end

    always_comb begin
        cnt_d   = accept ? WC : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        addr_d  = accept ? bus.addr : addr_q;
        data_d  = accept ? bus.data_in : data_q;
        wr_d    = accept ? bus.wr : wr_q;
        rdata_d = (access && !wr_q) ? (in_range ? mem_q[idx] : '0) : rdata_q;
        ready_d = access;
        error_d = illegal || (access && !in_range);
    end

    assign bus.data_out = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (WAIT_CYCLES 2 and 0).
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [25:0] addr = '0;
    logic [31:0] wdata = '0;
    int          vectors = 0, miscompares = 0, cyc = 0;

    mem_responder_if #(.ADDR_WIDTH(26)) bus ();
    mem_responder_if #(.ADDR_WIDTH(26)) bus0 ();

    assign bus.addr     = addr;
    assign bus.data_in  = wdata;
    assign bus.rd       = rd;
    assign bus.wr       = wr;
    assign bus0.addr    = addr;
    assign bus0.data_in = wdata;
    assign bus0.rd      = rd;
    assign bus0.wr      = wr;

    mem_responder #(.ADDR_WIDTH(26), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );
    mem_responder #(.ADDR_WIDTH(26), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one access; addr/data switch to a2/d2 during BUSY; returns at the negedge where READY is seen
    task automatic acc(input logic w, input logic [25:0] a, input logic [31:0] d,
                       input logic [25:0] a2, input logic [31:0] d2,
                       output logic [31:0] q, output logic e, output int lat);
        @(negedge clk);
        rd = !w; wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        addr = a2; wdata = d2;
        lat = 0;
        while (!bus.ready && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0;
        q = bus.data_out;
        e = bus.error;
    endtask

    logic [31:0] q;
    logic        e;
    int          lat, nrdy;
    int          t2[$], t0[$];

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        acc(1'b1, 26'h000, 32'h11110000, 26'h000, 32'h11110000, q, e, lat);
        chk("wr0_lat", lat, 3);
        chk("wr0_err", e, 0);
        acc(1'b1, 26'h010, 32'h0BADF00D, 26'h010, 32'h0BADF00D, q, e, lat);
        chk("wr10_err", e, 0);

        acc(1'b1, 26'h005, 32'hDEADBEEF, 26'h005, 32'hDEADBEEF, q, e, lat);
        chk("wr5_lat", lat, 3);
        chk("wr5_err", e, 0);
        acc(1'b0, 26'h005, 32'h0, 26'h005, 32'h0, q, e, lat);
        chk("rd5_lat", lat, 3);
        chk("rd5_data", q, 32'hDEADBEEF);
        chk("rd5_err", e, 0);
        @(negedge clk);
        chk("rd5_ready_fall", bus.ready, 0);
        chk("rd5_data_hold", bus.data_out, 32'hDEADBEEF);

        // reset during DONE clears outputs without a clock edge
        acc(1'b0, 26'h005, 32'h0, 26'h005, 32'h0, q, e, lat);
        chk("rd5b_ready", bus.ready, 1);
        rd = 1'b1; addr = 26'h3FF;
        rst_n = 1'b0;
        #1;
        chk("rst_data", bus.data_out, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_error", bus.error, 0);
        rd = 1'b0;
        #2 rst_n = 1'b1;

        acc(1'b1, 26'h400, 32'h12345678, 26'h400, 32'h12345678, q, e, lat);
        chk("oor_wr_lat", lat, 3);
        chk("oor_wr_err", e, 1);
        acc(1'b0, 26'h400, 32'h0, 26'h400, 32'h0, q, e, lat);
        chk("oor_rd_data", q, 0);
        chk("oor_rd_err", e, 1);
        acc(1'b0, 26'h000, 32'h0, 26'h000, 32'h0, q, e, lat);
        chk("rd0_noalias", q, 32'h11110000);
        chk("rd0_err", e, 0);

        // illegal: both strobes in IDLE
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 26'h005; wdata = 32'h55555555;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk("ill_err", bus.error, 1);
        chk("ill_ready", bus.ready, 0);
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ready) nrdy++;
        end
        chk("ill_err_fall", bus.error, 0);
        chk("ill_no_ready", nrdy, 0);
        acc(1'b0, 26'h005, 32'h0, 26'h005, 32'h0, q, e, lat);
        chk("ill_store", q, 32'hDEADBEEF);

        // abort a write one cycle after acceptance
        @(negedge clk);
        wr = 1'b1; addr = 26'h010; wdata = 32'hAAAA5555;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acc(1'b0, 26'h010, 32'h0, 26'h010, 32'h0, q, e, lat);
        chk("abort_old", q, 32'h0BADF00D);

        // inputs changed during BUSY must not affect the access
        acc(1'b1, 26'h020, 32'hCAFEF00D, 26'h005, 32'h0, q, e, lat);
        chk("iso_wr_lat", lat, 3);
        acc(1'b0, 26'h020, 32'h0, 26'h000, 32'h0, q, e, lat);
        chk("iso_rd_data", q, 32'hCAFEF00D);
        acc(1'b0, 26'h005, 32'h0, 26'h005, 32'h0, q, e, lat);
        chk("iso_rd5", q, 32'hDEADBEEF);

        // back-to-back reads with READ held high
        acc(1'b1, 26'h001, 32'h01234567, 26'h001, 32'h01234567, q, e, lat);
        repeat (3) @(negedge clk);
        rd = 1'b1; addr = 26'h001;
        repeat (20) begin
            @(negedge clk);
            if (bus.ready) begin
                t2.push_back(cyc);
                chk("b2b_data", bus.data_out, 32'h01234567);
            end
            if (bus0.ready) begin
                t0.push_back(cyc);
                chk("b2b0_data", bus0.data_out, 32'h01234567);
            end
        end
        rd = 1'b0;
        chk("b2b_count", t2.size() >= 3, 1);
        chk("b2b0_count", t0.size() >= 5, 1);
        if (t2.size() >= 3) begin
            chk("b2b_gap1", t2[1] - t2[0], 5);
            chk("b2b_gap2", t2[2] - t2[1], 5);
        end
        if (t0.size() >= 3) begin
            chk("b2b0_gap1", t0[1] - t0[0], 3);
            chk("b2b0_gap2", t0[2] - t0[1], 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 32-bit processor's memory port. It accepts word read and write requests on the address, data and strobe signals driven by the processor datapath. It holds a parameterized word-addressed backing store and completes each access after a programmable number of wait states, signalling completion with a one-cycle READY pulse. It sits between the datapath/control unit and system memory and replaces the zero-latency memory model, so the control unit can be exercised against realistic access latency.

## Interface
- ADDR_WIDTH, 26: width of the word address from the datapath.
- DEPTH_LOG2, 10: backing store holds 2**DEPTH_LOG2 32-bit words; must be ≤ ADDR_WIDTH.
- WAIT_CYCLES, 2: wait states inserted per access; legal range 0..15.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ADDR  in  ADDR_WIDTH  word address of request.
- DATA_IN  in  32  write data (processor's outgoing data).
- READ  in  1  read request strobe, level.
- WRITE  in  1  write request strobe, level.
- DATA_OUT  out  32  read data; valid when READY=1 for a read.
- READY  out  1  one-cycle completion pulse.
- ERROR  out  1  one-cycle error flag, coincident with READY or standalone (see below).

## Operation
- States: IDLE, BUSY, DONE. Wait counter is 4 bits.
- IDLE, READ xor WRITE = 1 at an edge: capture ADDR, DATA_IN and op into internal registers; counter := WAIT_CYCLES; go to BUSY.
- IDLE, READ = WRITE = 1 at an edge: no access. ERROR = 1 for the next cycle with READY = 0. Stay in IDLE.
- BUSY, counter ≠ 0: counter decrements. BUSY, counter = 0: perform the access at this edge and go to DONE.
  - Write: store[captured addr] := captured data.
  - Read: DATA_OUT := store[captured addr].
- DONE: READY = 1 for exactly this cycle. The next edge returns to IDLE unconditionally. Strobes sampled in DONE are ignored.
- Strobe changes or ADDR/DATA_IN changes while in BUSY/DONE have no effect, because captured values are used.
- Range check: a captured address ≥ 2**DEPTH_LOG2 is out of range.
  - Write: discarded.
  - Read: DATA_OUT := 0.
  - ERROR = 1 together with READY in DONE.
- In range, ERROR = 0 in DONE.
- DATA_OUT holds its last value until the next read completes. Writes do not change it.
- Holding a strobe high past DONE starts a new, repeated access in the following IDLE cycle. The requester must drop the strobe in the cycle after it sees READY.
- Address index uses ADDR[DEPTH_LOG2-1:0] after the range check.

## Timing
- Reset (RST=0, asynchronous): state := IDLE, counter := 0, DATA_OUT := 0, READY := 0, ERROR := 0, captured registers := 0.
- Backing store contents are not cleared by reset.
- Reset asserted in BUSY aborts the access: a pending write is not performed.
- Reset asserted during the DONE cycle: outputs go to 0 immediately. The write done at the preceding edge persists.
- Acceptance edge = E0. Access edge = E0+WAIT_CYCLES+1. READY high in the cycle following that edge. IDLE again at E0+WAIT_CYCLES+2. Earliest next acceptance is E0+WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- WAIT_CYCLES=0: READY in the cycle after E0+1.
- A read issued after a write to the same address returns the new data, since accesses are serialized.
- READY and ERROR are registered outputs with no combinational path from inputs.

## Test plan
Parameters for all scenarios: defaults (WAIT_CYCLES=2, DEPTH_LOG2=10).

1. Reset values: RST low mid-simulation, with any inputs.
   - Required: DATA_OUT=0, READY=0, ERROR=0 immediately, before any clock edge.
2. Write then read:
   - Stimulus: WRITE, ADDR=0x005, DATA_IN=0xDEADBEEF; drop WRITE on READY. Then READ ADDR=0x005.
   - Required: each READY appears exactly 3 cycles after its acceptance edge. Read DATA_OUT=0xDEADBEEF with ERROR=0.
   - Required: DATA_OUT stays 0xDEADBEEF after READY falls.
3. Out of range:
   - Stimulus: WRITE ADDR=0x400 (1024), DATA_IN=0x12345678, then READ ADDR=0x400.
   - Required: both complete with READY=1, ERROR=1. Read returns 0x00000000.
   - Required: READ ADDR=0x000 still returns its prior content, so the index did not alias to 0.
4. Illegal request: READ=WRITE=1 in IDLE.
   - Required: ERROR=1 for one cycle, READY never asserted, store unchanged.
5. Abort and input isolation:
   - Stimulus: WRITE ADDR=0x010, DATA_IN=0xAAAA5555, then pull RST low one cycle after acceptance.
   - Required: a subsequent read of 0x010 returns its old value.
   - Stimulus: separately, change ADDR and DATA_IN during BUSY.
   - Required: the access uses the captured values.
6. Back-to-back: hold READ high continuously at ADDR=0x001.
   - Required: READY pulses every 5 cycles with the same data.
   - Required: with WAIT_CYCLES=0, READY pulses every 3 cycles.
